// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: decode in ID, control bits carried through ID/EX, EX/MEM, MEM/WB (ex +1, mem +2, wb +3 cycles).
// Backpressure: freeze holds every stage; load-use hazard_stall holds PC/IF-ID and bubbles ID/EX.
module pipe_ctrl_unit #(
    parameter int OPW     = 4,
    parameter int RAW     = 3,
    parameter int ALUOPW  = 2,
    parameter int ZERO_HW = 1,
    parameter int CNTW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OPW-1:0]    id_opcode,
    input  logic [RAW-1:0]    id_rs,
    input  logic [RAW-1:0]    id_rt,
    input  logic [RAW-1:0]    id_dst,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic              ex_alu_src,
    output logic [ALUOPW-1:0] ex_alu_op,
    output logic              ex_illegal,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [RAW-1:0]    wb_dst,
    output logic [CNTW-1:0]   stall_cnt
);

    localparam logic [OPW-1:0] OP_ADD   = OPW'(4'b0000);
    localparam logic [OPW-1:0] OP_NANDI = OPW'(4'b0001);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(4'b0011);
    localparam logic [OPW-1:0] OP_LW    = OPW'(4'b0111);
    localparam logic [OPW-1:0] OP_SW    = OPW'(4'b0110);
    localparam logic [OPW-1:0] OP_NOR   = OPW'(4'b1111);

    localparam logic [ALUOPW-1:0] ALU_ADD  = ALUOPW'(2'b00);
    localparam logic [ALUOPW-1:0] ALU_SUB  = ALUOPW'(2'b01);
    localparam logic [ALUOPW-1:0] ALU_NAND = ALUOPW'(2'b10);
    localparam logic [ALUOPW-1:0] ALU_NOR  = ALUOPW'(2'b11);

    typedef struct packed {
        logic              valid;
        logic              alu_src;
        logic [ALUOPW-1:0] alu_op;
        logic              illegal;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [RAW-1:0]    dst;
    } ex_ctrl_t;

    typedef struct packed {
        logic           mem_read;
        logic           mem_write;
        logic           mem_to_reg;
        logic           reg_write;
        logic [RAW-1:0] dst;
    } mem_ctrl_t;

    typedef struct packed {
        logic           mem_to_reg;
        logic           reg_write;
        logic [RAW-1:0] dst;
    } wb_ctrl_t;

    ex_ctrl_t  dec;
    ex_ctrl_t  ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;
    logic      uses_rt;
    logic      undefined;
    logic      ex_dst_live;

    always_comb begin
        dec       = '0;
        uses_rt   = 1'b0;
        undefined = 1'b0;
        case (id_opcode)
            OP_ADD: begin
                dec.alu_op    = ALU_ADD;
                dec.reg_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_NANDI: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_NAND;
                dec.reg_write = 1'b1;
            end
            OP_SUB: begin
                dec.alu_op    = ALU_SUB;
                dec.reg_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_ADD;
                dec.mem_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_NOR: begin
                dec.alu_op    = ALU_NOR;
                dec.reg_write = 1'b1;
                uses_rt       = 1'b1;
            end
            default: undefined = 1'b1;
        endcase
        if ((ZERO_HW != 0) && (id_dst == '0)) begin
            dec.reg_write = 1'b0;
        end
        dec.dst   = id_dst;
        dec.valid = 1'b1;
        // Undefined opcodes travel as a bubble that only carries the illegal flag.
        if (!id_valid || undefined) begin
            dec = '0;
        end
        dec.illegal = id_valid & undefined;
    end

    assign ex_dst_live  = (ZERO_HW == 0) || (ex_q.dst != '0);
    assign hazard_stall = id_valid & ex_q.valid & ex_q.mem_read & ex_dst_live &
                          ((ex_q.dst == id_rs) | (uses_rt & (ex_q.dst == id_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else if (!freeze) begin
            ex_q            <= (flush | hazard_stall) ? '0 : dec;
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.dst        <= ex_q.dst;
            wb_q.mem_to_reg  <= mem_q.mem_to_reg;
            wb_q.reg_write   <= mem_q.reg_write;
            wb_q.dst         <= mem_q.dst;
            if (hazard_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_illegal    = ex_q.illegal;
    assign mem_mem_read  = mem_q.mem_read;
    assign mem_mem_write = mem_q.mem_write;
    assign wb_mem_to_reg = wb_q.mem_to_reg;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_dst        = wb_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; writeback results are scoreboarded through a queue.
// A narrow stall counter keeps the saturation run short.
module tb_pipe_ctrl_unit;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic          id_valid = 1'b0;
    logic [3:0]    id_opcode = '0;
    logic [2:0]    id_rs = '0;
    logic [2:0]    id_rt = '0;
    logic [2:0]    id_dst = '0;
    logic          hazard_stall;
    logic          ex_valid;
    logic          ex_alu_src;
    logic [1:0]    ex_alu_op;
    logic          ex_illegal;
    logic          mem_mem_read;
    logic          mem_mem_write;
    logic          wb_mem_to_reg;
    logic          wb_reg_write;
    logic [2:0]    wb_dst;
    logic [CW-1:0] stall_cnt;

    pipe_ctrl_unit #(
        .OPW(4), .RAW(3), .ALUOPW(2), .ZERO_HW(1), .CNTW(CW)
    ) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic       rw;
        logic [2:0] dst;
        logic       m2r;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   pc = 0;
    int   exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] dst);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_dst    = dst;
        #1;
    endtask

    // Capture happens on the next advancing edge, so writeback is visible three advancing edges on.
    task automatic push(input logic rw, input logic [2:0] dst, input logic m2r);
        exp_t e;
        e.due = pc + 3;
        e.rw  = rw;
        e.dst = dst;
        e.m2r = m2r;
        sbq.push_back(e);
    endtask

    task automatic step(input bit adv);
        @(posedge clk);
        if (adv) pc++;
        @(negedge clk);
        if (adv) begin
            if (sbq.size() > 0 && sbq[0].due == pc) begin
                exp_t e;
                e = sbq.pop_front();
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("wb_dst", 32'(wb_dst), 32'(e.dst));
                chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e.m2r));
            end else begin
                chk("wb_idle", 32'(wb_reg_write), 32'd0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_hazard"}, 32'(hazard_stall), 32'd0);
        chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_ex_alu_src"}, 32'(ex_alu_src), 32'd0);
        chk({tag, "_ex_alu_op"}, 32'(ex_alu_op), 32'd0);
        chk({tag, "_ex_illegal"}, 32'(ex_illegal), 32'd0);
        chk({tag, "_mem_read"}, 32'(mem_mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_mem_write), 32'd0);
        chk({tag, "_wb_m2r"}, 32'(wb_mem_to_reg), 32'd0);
        chk({tag, "_wb_rw"}, 32'(wb_reg_write), 32'd0);
        chk({tag, "_wb_dst"}, 32'(wb_dst), 32'd0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all_zero("por");
        rst = 1'b0;

        // add r1 then sub r3
        drive(1, 4'b0000, 3'd3, 3'd4, 3'd1); push(1, 3'd1, 0); step(1);
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_ex_alu_op", 32'(ex_alu_op), 32'd0);
        drive(1, 4'b0011, 3'd5, 3'd6, 3'd3); push(1, 3'd3, 0); step(1);
        chk("sub_ex_alu_op", 32'(ex_alu_op), 32'd1);
        chk("sub_ex_alu_src", 32'(ex_alu_src), 32'd0);
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0);
        step(1); step(1); step(1);

        // Load-use: lw r2 then add rs=r2
        drive(1, 4'b0111, 3'd1, 3'd0, 3'd2); push(1, 3'd2, 1); step(1);
        chk("lw_ex_alu_src", 32'(ex_alu_src), 32'd1);
        drive(1, 4'b0000, 3'd2, 3'd3, 3'd4);
        chk("lu_hazard_on", 32'(hazard_stall), 32'd1);
        step(1);
        chk("lu_ex_bubble", 32'(ex_valid), 32'd0);
        chk("lu_mem_read", 32'(mem_mem_read), 32'd1);
        chk("lu_hazard_off", 32'(hazard_stall), 32'd0);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        push(1, 3'd4, 0); step(1);
        chk("lu_add_late", 32'(ex_valid), 32'd1);
        exp_cnt = 1;

        // nandi does not read rt; lw to r0 never stalls
        drive(1, 4'b0111, 3'd1, 3'd0, 3'd2); push(1, 3'd2, 1); step(1);
        drive(1, 4'b0001, 3'd5, 3'd2, 3'd3);
        chk("nandi_no_hazard", 32'(hazard_stall), 32'd0);
        push(1, 3'd3, 0); step(1);
        chk("nandi_alu_op", 32'(ex_alu_op), 32'd2);
        chk("nandi_alu_src", 32'(ex_alu_src), 32'd1);
        drive(1, 4'b0111, 3'd1, 3'd0, 3'd0); push(0, 3'd0, 1); step(1);
        drive(1, 4'b0000, 3'd0, 3'd0, 3'd5);
        chk("r0_no_hazard", 32'(hazard_stall), 32'd0);
        push(1, 3'd5, 0); step(1);
        chk("r0_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0);
        step(1); step(1); step(1);

        // Freeze with flush held over a queued sw
        drive(1, 4'b0000, 3'd1, 3'd2, 3'd6); push(1, 3'd6, 0); step(1);
        drive(1, 4'b0110, 3'd1, 3'd2, 3'd0);
        freeze = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0);
            chk("frz_ex_valid", 32'(ex_valid), 32'd1);
            chk("frz_ex_alu_src", 32'(ex_alu_src), 32'd0);
            chk("frz_mem_write", 32'(mem_mem_write), 32'd0);
        end
        freeze = 1'b0; flush = 1'b0;
        push(0, 3'd0, 0); step(1);
        chk("sw_ex_alu_src", 32'(ex_alu_src), 32'd1);
        chk("sw_mem_write_early", 32'(mem_mem_write), 32'd0);
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0); step(1);
        chk("sw_mem_write", 32'(mem_mem_write), 32'd1);

        // Plain flush kills the ID instruction
        drive(1, 4'b0000, 3'd1, 3'd1, 3'd7); flush = 1'b1; step(1);
        chk("flush_bubble", 32'(ex_valid), 32'd0);
        flush = 1'b0;
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0);
        step(1); step(1); step(1);

        // Undefined opcode
        drive(1, 4'b1010, 3'd1, 3'd2, 3'd3); push(0, 3'd0, 0); step(1);
        chk("ill_flag", 32'(ex_illegal), 32'd1);
        chk("ill_ex_valid", 32'(ex_valid), 32'd0);
        chk("ill_alu_src", 32'(ex_alu_src), 32'd0);
        chk("ill_alu_op", 32'(ex_alu_op), 32'd0);
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0); step(1);
        chk("ill_one_cycle", 32'(ex_illegal), 32'd0);
        chk("ill_mem_read", 32'(mem_mem_read), 32'd0);
        step(1); step(1);

        // Back-to-back self-dependent loads drive the counter into saturation
        drive(1, 4'b0111, 3'd2, 3'd0, 3'd2); push(1, 3'd2, 1); step(1);
        for (int i = 0; i < (2 ** CW) + 3; i++) begin
            chk("sat_hazard", 32'(hazard_stall), 32'd1);
            if (i == 3) begin
                freeze = 1'b1;
                step(0); step(0);
                chk("frz_stall_cnt_hold", 32'(stall_cnt), 32'(exp_cnt));
                freeze = 1'b0;
            end
            step(1);
            if (exp_cnt < (2 ** CW) - 1) exp_cnt++;
            chk("sat_stall_cnt", 32'(stall_cnt), 32'(exp_cnt));
            push(1, 3'd2, 1); step(1);
        end
        chk("sat_all_ones", 32'(stall_cnt), 32'((2 ** CW) - 1));
        drive(0, 4'b0000, 3'd0, 3'd0, 3'd0);
        step(1); step(1); step(1);

        // Asynchronous reset with three instructions in flight and a stall pending
        drive(1, 4'b0000, 3'd1, 3'd1, 3'd1); push(1, 3'd1, 0); step(1);
        drive(1, 4'b0001, 3'd1, 3'd0, 3'd3); push(1, 3'd3, 0); step(1);
        drive(1, 4'b0111, 3'd1, 3'd0, 3'd2); push(1, 3'd2, 1); step(1);
        drive(1, 4'b0000, 3'd2, 3'd3, 3'd4);
        chk("pre_rst_hazard", 32'(hazard_stall), 32'd1);
        chk("pre_rst_wb", 32'(wb_reg_write), 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 4'b0000, 3'd2, 3'd3, 3'd4); push(1, 3'd4, 0); step(1);
        chk("post_rst_ex_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_cnt", 32'(stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
